// File: rtl/romulator_pkg.sv
// Shared definitions for the romulator SRAM arbitration path.
// Owner encoding, FSM state type and synchroniser depth.
// No logic; imported by ram_bus_arbiter and its bench.
package romulator_pkg;

    // Owner encoding as seen on the owner output
    localparam logic [1:0] OWN_LOAD      = 2'd0;
    localparam logic [1:0] OWN_CPU       = 2'd1;
    localparam logic [1:0] OWN_HALT_WAIT = 2'd2;
    localparam logic [1:0] OWN_DIAG      = 2'd3;

    // Flops in the phi2 / rwbar synchronisers
    localparam int SYNC_STAGES = 2;

    // State values equal the owner encoding so owner is the raw state register
    typedef enum logic [1:0] {
        ST_LOAD      = OWN_LOAD,
        ST_RUN       = OWN_CPU,
        ST_HALT_WAIT = OWN_HALT_WAIT,
        ST_DIAG      = OWN_DIAG
    } arb_state_e;

endpackage

// File: rtl/vram_window_decode.sv
// Purpose : decode NUM_WIN [start,end) VRAM windows against an address, lowest index wins.
// Latency : purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle.
// Ports   : addr_i (address under test), win_start_i/win_end_i (packed per-window bounds),
//           hit_o (any window hit), offset_o (addr - start of winning window, truncated; 0 on miss).
module vram_window_decode #(
    parameter int ADDR_W  = 16,
    parameter int NUM_WIN = 2,
    parameter int VRAM_AW = 11
) (
    input  logic [ADDR_W-1:0]         addr_i,
    input  logic [NUM_WIN*ADDR_W-1:0] win_start_i,
    input  logic [NUM_WIN*ADDR_W-1:0] win_end_i,
    output logic                      hit_o,
    output logic [VRAM_AW-1:0]        offset_o
);

    logic [NUM_WIN-1:0] win_hit;
    logic [VRAM_AW-1:0] sel_start_lo;

    // A window with start >= end can never satisfy both compares, so it is disabled for free.
    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            win_hit[i] = (addr_i >= win_start_i[i*ADDR_W +: ADDR_W]) &&
                         (addr_i <  win_end_i[i*ADDR_W +: ADDR_W]);
        end
    end

    // Scan from the top down so the lowest hitting index is the last assignment.
    // Only the low VRAM_AW bits of the start are needed: the truncated difference
    // of the low bits equals the low bits of the full-width difference.
    always_comb begin
        sel_start_lo = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (win_hit[i]) begin
                sel_start_lo = win_start_i[i*ADDR_W +: VRAM_AW];
            end
        end
    end

    assign hit_o    = |win_hit;
    assign offset_o = hit_o ? (addr_i[VRAM_AW-1:0] - sel_start_lo) : '0;

endmodule

// File: rtl/ram_bus_arbiter.sv
// Purpose : registered owner arbiter for the shared 64K SRAM (flash loader -> CPU -> diagnostics) plus VRAM window decode.
// Latency : request mux and window decode add zero cycles; owner changes on the clock edge after its trigger is sampled.
// Backpressure: CPU is stalled through rdy (low outside RUN); diagnostics wait for halt_ack before driving the bus.
//
// Ports   : clk_i/rst_i (async active-high reset); load_done_i; fl_*, cpu_*, dg_* RAM requests;
//           phi2_i/rwbar_i raw async CPU timing; dg_halt_req_i; win_start_i/win_end_i window bounds;
//           ram_* muxed SRAM request; owner_o, rdy_o, halt_ack_o, data_oe_o; vram_we_o/vram_addr_o.
// Option  : WRITE_PROTECT_EN adds wp_start_i/wp_end_i and sticky wp_hit_o; CPU writes into
//           [wp_start, wp_end) are dropped. wp_end_i == 0 means "up to the top of the address space".
module ram_bus_arbiter
    import romulator_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int NUM_WIN    = 2,
    parameter int VRAM_AW    = 11,
    parameter int SETTLE_CYC = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      load_done_i,
    input  logic [ADDR_W-1:0]         fl_addr_i,
    input  logic [DATA_W-1:0]         fl_din_i,
    input  logic                      fl_cs_i,
    input  logic                      fl_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [DATA_W-1:0]         cpu_din_i,
    input  logic                      cpu_cs_i,
    input  logic                      cpu_we_i,
    input  logic                      phi2_i,
    input  logic                      rwbar_i,
    input  logic                      dg_halt_req_i,
    input  logic [ADDR_W-1:0]         dg_addr_i,
    input  logic [DATA_W-1:0]         dg_din_i,
    input  logic                      dg_cs_i,
    input  logic                      dg_we_i,
    input  logic [NUM_WIN*ADDR_W-1:0] win_start_i,
    input  logic [NUM_WIN*ADDR_W-1:0] win_end_i,
    output logic [ADDR_W-1:0]         ram_addr_o,
    output logic [DATA_W-1:0]         ram_din_o,
    output logic                      ram_cs_o,
    output logic                      ram_we_o,
    output logic [1:0]                owner_o,
    output logic                      rdy_o,
    output logic                      halt_ack_o,
    output logic                      data_oe_o,
    output logic                      vram_we_o,
    output logic [VRAM_AW-1:0]        vram_addr_o
`ifdef WRITE_PROTECT_EN
    ,
    input  logic [ADDR_W-1:0]         wp_start_i,
    input  logic [ADDR_W-1:0]         wp_end_i,
    output logic                      wp_hit_o
`endif
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    arb_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic                   load_done_q;
    logic [SYNC_STAGES-1:0] phi2_sync_q;
    logic [SYNC_STAGES-1:0] rwbar_sync_q;
    logic                   phi2_prev_q;
    logic                   phi2_fall;
    logic                   cpu_sel;
    logic                   mux_we;
    logic                   wp_block;
    logic                   win_hit;
    logic [VRAM_AW-1:0]     win_offset;

    // ------------------------------------------------------------------
    // State, counter, sticky load latch and synchronisers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_LOAD;
            cnt_q        <= '0;
            load_done_q  <= 1'b0;
            phi2_sync_q  <= '0;
            rwbar_sync_q <= '0;
            phi2_prev_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            load_done_q  <= load_done_q | load_done_i;
            phi2_sync_q  <= {phi2_sync_q[SYNC_STAGES-2:0], phi2_i};
            rwbar_sync_q <= {rwbar_sync_q[SYNC_STAGES-2:0], rwbar_i};
            phi2_prev_q  <= phi2_sync_q[SYNC_STAGES-1];
        end
    end

    assign phi2_fall = phi2_prev_q & ~phi2_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Next-state logic. cnt_q == 0 in HALT_WAIT means "waiting for phi2 to fall";
    // a non-zero value is the remaining settle time. The grant is taken on the edge
    // where the count would reach zero, so DIAG starts SETTLE_CYC edges after the load.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (load_done_i || load_done_q) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (dg_halt_req_i) begin
                    state_d = ST_HALT_WAIT;
                end
            end
            ST_HALT_WAIT: begin
                if (!dg_halt_req_i) begin
                    // Withdrawal beats a pending grant
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    if (phi2_fall) begin
                        cnt_d = SETTLE_LD;
                    end
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_DIAG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DIAG: begin
                if (!dg_halt_req_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request mux: CPU keeps the bus through HALT_WAIT so the current cycle completes.
    // ------------------------------------------------------------------
    assign cpu_sel = (state_q == ST_RUN) || (state_q == ST_HALT_WAIT);

    always_comb begin
        ram_addr_o = fl_addr_i;
        ram_din_o  = fl_din_i;
        ram_cs_o   = fl_cs_i;
        mux_we     = fl_we_i;
        if (cpu_sel) begin
            ram_addr_o = cpu_addr_i;
            ram_din_o  = cpu_din_i;
            ram_cs_o   = cpu_cs_i;
            mux_we     = cpu_we_i;
        end else if (state_q == ST_DIAG) begin
            ram_addr_o = dg_addr_i;
            ram_din_o  = dg_din_i;
            ram_cs_o   = dg_cs_i;
            mux_we     = dg_we_i;
        end
    end

`ifdef WRITE_PROTECT_EN
    logic wp_in_range;
    logic wp_hit_q;

    assign wp_in_range = (cpu_addr_i >= wp_start_i) &&
                         ((wp_end_i == '0) || (cpu_addr_i < wp_end_i));
    // Only CPU-owned writes are filtered; loader and diagnostics may patch ROM images.
    assign wp_block    = cpu_sel & cpu_cs_i & cpu_we_i & wp_in_range;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wp_hit_q <= 1'b0;
        end else if (wp_block) begin
            wp_hit_q <= 1'b1;
        end
    end

    assign wp_hit_o = wp_hit_q;
`else
    assign wp_block = 1'b0;
`endif

    assign ram_we_o = mux_we & ~wp_block;

    // ------------------------------------------------------------------
    // VRAM mirror: decoded in every state so loaded images reach VRAM too.
    // ------------------------------------------------------------------
    vram_window_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_WIN (NUM_WIN),
        .VRAM_AW (VRAM_AW)
    ) u_win (
        .addr_i      (ram_addr_o),
        .win_start_i (win_start_i),
        .win_end_i   (win_end_i),
        .hit_o       (win_hit),
        .offset_o    (win_offset)
    );

    assign vram_we_o   = ram_we_o & win_hit;
    assign vram_addr_o = win_offset;

    // ------------------------------------------------------------------
    // Status outputs, all decoded from the registered state.
    // ------------------------------------------------------------------
    assign owner_o    = state_q;
    assign rdy_o      = (state_q == ST_RUN);
    assign halt_ack_o = (state_q == ST_DIAG);
    assign data_oe_o  = (state_q == ST_RUN) & rwbar_sync_q[SYNC_STAGES-1] & cpu_cs_i;

endmodule
